dmem_arbiter: RTL and testbench

Sequences the single data memory and shares it between two requesters. The pipeline MEM stage has priority. An external loader/debug port is the second requester. The block drives the memory's multi-cycle access timing, stalls the pipeline while a MEM-stage access is outstanding, and guarantees the external port cannot be starved. It sits between the EX/MEM register outputs (address, write data, memRead/memWrite) and the data memory, and feeds read data to MEM/WB.

---
 rtl/dmem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Sequences the single data memory and shares it between the pipeline MEM
// stage (priority requester) and an external loader/debug port.  Each access
// holds address/controls for ACCESS_CYCLES cycles.  The last of these is the
// "done" cycle, and one IDLE cycle always separates two accesses.  A streak
// counter bounds how many consecutive pipeline grants may be made while the
// external port waits, so the external port cannot be starved.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   pipe_*          MEM-stage request (req/we/addr/wdata), load data and stall
//   ext_*           external request (held until ext_done), read data, done pulse
//   mem_*           memory address/data/strobes; mem_rdata valid in the done cycle
//   busy            an access is in progress
//   stall_count     saturating count of cycles with pipe_stall=1
module dmem_arbiter #(
  parameter int unsigned ACCESS_CYCLES   = 2,
  parameter int unsigned MAX_PIPE_STREAK = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  // pipeline MEM stage
  input  logic             pipe_req,
  input  logic             pipe_we,
  input  logic [31:0]      pipe_addr,
  input  logic [31:0]      pipe_wdata,
  output logic [31:0]      pipe_rdata,
  output logic             pipe_stall,
  // external loader / debug port
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  output logic [31:0]      ext_rdata,
  output logic             ext_done,
  // data memory
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  // Access cycle counter runs 1..ACCESS_CYCLES; streak runs 0..MAX_PIPE_STREAK.
  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);
  localparam int unsigned SW = (MAX_PIPE_STREAK < 1) ? 1 : $clog2(MAX_PIPE_STREAK + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_PIPE_STREAK);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pipe_rdata_q;
  logic [31:0]       ext_rdata_q;
  logic [CNT_W-1:0]  stall_q;

  // ---------------------------------------------------------------------------
  // Access phase decode
  // ---------------------------------------------------------------------------
  // Reset is synchronous, so the state register still reads ACCESS during the
  // reset cycle.  Qualifying with !rst keeps an aborted access from driving
  // the memory, pulsing mem_we or signalling completion.
  logic access_active;
  logic done;
  logic done_pipe;
  logic done_ext;

  assign access_active = (state_q == ACCESS) && !rst;
  assign done          = access_active && (cnt_q == CNT_LAST);
  assign done_pipe     = done && (owner_q == OWN_PIPE);
  assign done_ext      = done && (owner_q == OWN_EXT);

  // ---------------------------------------------------------------------------
  // Next-state / arbitration
  // ---------------------------------------------------------------------------
  logic grant_pipe;
  logic grant_ext;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_pipe = 1'b0;
    grant_ext  = 1'b0;

    case (state_q)
      IDLE: begin
        // Pipeline has priority unless it has already won MAX_PIPE_STREAK
        // grants in a row while the external port was waiting.
        if (pipe_req && !(ext_req && (streak_q == STREAK_MAX))) begin
          grant_pipe = 1'b1;
        end else if (ext_req) begin
          grant_ext = 1'b1;
        end

        // Nobody is waiting on the external side: the streak restarts.
        if (!ext_req) begin
          streak_d = '0;
        end

        if (grant_pipe) begin
          state_d = ACCESS;
          owner_d = OWN_PIPE;
          cnt_d   = CW'(1);
          we_d    = pipe_we;
          addr_d  = pipe_addr;
          wdata_d = pipe_wdata;
          // A pipe grant with ext_req pending implies streak < max, so the
          // increment saturates naturally at STREAK_MAX.
          if (ext_req) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_ext) begin
          state_d  = ACCESS;
          owner_d  = OWN_EXT;
          cnt_d    = CW'(1);
          we_d     = ext_we;
          addr_d   = ext_addr;
          wdata_d  = ext_wdata;
          streak_d = '0;
        end
      end

      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      cnt_q        <= '0;
      streak_q     <= '0;
      // NOTE: the latched request fields are datapath registers and are only
      // observed through access_active; they are cleared anyway so nothing
      // stale is ever visible when inspecting the block after reset.
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pipe_rdata_q <= '0;
      ext_rdata_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;

      // Capture load data so it remains visible after the done cycle.
      if (done_pipe && !we_q) begin
        pipe_rdata_q <= mem_rdata;
      end
      if (done_ext && !we_q) begin
        ext_rdata_q <= mem_rdata;
      end

      if (pipe_stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The byte offset is masked rather than dropped so the memory always sees
  // a word-aligned address.
  assign mem_addr    = access_active ? (addr_q & 32'hFFFF_FFFC) : '0;
  assign mem_wdata   = access_active ? wdata_q : '0;
  assign mem_re      = access_active && !we_q;
  // Write strobe only in the final cycle: exactly one pulse per write access.
  assign mem_we      = done && we_q;

  assign busy        = (state_q == ACCESS);
  assign ext_done    = done_ext;

  // The pipeline stalls whenever it requests, except in the done cycle of
  // its own access; that includes waiting behind an external access.
  assign pipe_stall  = !rst && pipe_req && !done_pipe;

  // Combinational bypass in the done cycle so MEM/WB gets the load data
  // without an extra cycle; otherwise the last loaded value is held.
  assign pipe_rdata  = (done_pipe && !we_q) ? mem_rdata : pipe_rdata_q;
  assign ext_rdata   = (done_ext  && !we_q) ? mem_rdata : ext_rdata_q;

  assign stall_count = stall_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// ---------------
// Drives two dmem_arbiter instances with identical stimulus: the main one
// (CNT_W=16) and a narrow-counter one (CNT_W=2) whose stall_count must
// saturate at 3.  A behavioural model (remaining-cycle count, queue-free
// arbitration with an explicit streak) predicts every output on every cycle;
// directed steps add hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int AC       = 2;
  localparam int MPS      = 4;
  localparam int CW_MAIN  = 16;
  localparam int CW_SAT   = 2;
  localparam int SC_MAX   = (1 << CW_MAIN) - 1;
  localparam int SAT_MAX  = (1 << CW_SAT) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pipe_req, pipe_we;
  logic [31:0] pipe_addr, pipe_wdata;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [31:0] mem_rdata;

  // main instance outputs
  logic [31:0]        pipe_rdata, ext_rdata, mem_addr, mem_wdata;
  logic               pipe_stall, ext_done, mem_re, mem_we, busy;
  logic [CW_MAIN-1:0] stall_count;

  // narrow-counter instance outputs
  logic [31:0]       s_pipe_rdata, s_ext_rdata, s_mem_addr, s_mem_wdata;
  logic              s_pipe_stall, s_ext_done, s_mem_re, s_mem_we, s_busy;
  logic [CW_SAT-1:0] s_stall_count;

  dmem_arbiter #(.ACCESS_CYCLES(AC), .MAX_PIPE_STREAK(MPS), .CNT_W(CW_MAIN)) u_dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .stall_count(stall_count)
  );

  dmem_arbiter #(.ACCESS_CYCLES(AC), .MAX_PIPE_STREAK(MPS), .CNT_W(CW_SAT)) u_sat (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(s_pipe_rdata), .pipe_stall(s_pipe_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(s_ext_rdata), .ext_done(s_ext_done),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_re(s_mem_re), .mem_we(s_mem_we),
    .mem_rdata(mem_rdata), .busy(s_busy), .stall_count(s_stall_count)
  );

  // Memory seen by the DUTs (driven by the main instance).
  logic [31:0] tb_mem [0:255];
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_valid = 0;
  bit          m_busy;
  bit          m_ext;
  int          m_left;       // access cycles still to run, including this one
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_streak;
  int          m_sc;
  logic [31:0] m_prd, m_erd;
  logic [31:0] gmem [0:255];

  task automatic cmp_set(input string p,
                         input logic [31:0] a_prd, input logic a_stall,
                         input logic [31:0] a_erd, input logic a_edone,
                         input logic [31:0] a_maddr, input logic [31:0] a_mwdata,
                         input logic a_mre, input logic a_mwe, input logic a_busy,
                         input logic [31:0] a_sc,
                         input logic [31:0] e_prd, input logic e_stall,
                         input logic [31:0] e_erd, input logic e_edone,
                         input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                         input logic e_mre, input logic e_mwe, input logic e_busy,
                         input logic [31:0] e_sc);
    check({p, "pipe_rdata"}, a_prd, e_prd);
    check({p, "pipe_stall"}, 32'(a_stall), 32'(e_stall));
    check({p, "ext_rdata"}, a_erd, e_erd);
    check({p, "ext_done"}, 32'(a_edone), 32'(e_edone));
    check({p, "mem_addr"}, a_maddr, e_maddr);
    check({p, "mem_wdata"}, a_mwdata, e_mwdata);
    check({p, "mem_re"}, 32'(a_mre), 32'(e_mre));
    check({p, "mem_we"}, 32'(a_mwe), 32'(e_mwe));
    check({p, "busy"}, 32'(a_busy), 32'(e_busy));
    check({p, "stall_count"}, a_sc, e_sc);
  endtask

  always @(negedge clk) begin : model
    logic        act, fin, e_stall, e_mre, e_mwe, e_edone;
    logic [31:0] e_maddr, e_mwdata, e_prd, e_erd, rd;
    bit          pick_pipe, pick_ext;

    act      = m_busy && !rst;
    fin      = act && (m_left == 1);
    rd       = gmem[m_addr[9:2]];
    e_maddr  = act ? {m_addr[31:2], 2'b00} : 32'h0;
    e_mwdata = act ? m_wdata : 32'h0;
    e_mre    = act && !m_we;
    e_mwe    = fin && m_we;
    e_edone  = fin && m_ext;
    e_stall  = !rst && pipe_req && !(fin && !m_ext);
    e_prd    = (fin && !m_ext && !m_we) ? rd : m_prd;
    e_erd    = (fin &&  m_ext && !m_we) ? rd : m_erd;

    if (m_valid) begin
      cmp_set("", pipe_rdata, pipe_stall, ext_rdata, ext_done, mem_addr, mem_wdata,
              mem_re, mem_we, busy, 32'(stall_count),
              e_prd, e_stall, e_erd, e_edone, e_maddr, e_mwdata, e_mre, e_mwe,
              m_busy, 32'(m_sc));
      cmp_set("s_", s_pipe_rdata, s_pipe_stall, s_ext_rdata, s_ext_done, s_mem_addr,
              s_mem_wdata, s_mem_re, s_mem_we, s_busy, 32'(s_stall_count),
              e_prd, e_stall, e_erd, e_edone, e_maddr, e_mwdata, e_mre, e_mwe,
              m_busy, 32'((m_sc > SAT_MAX) ? SAT_MAX : m_sc));
    end

    // advance to the state after the coming rising edge
    if (rst) begin
      m_valid  = 1;
      m_busy   = 0;
      m_ext    = 0;
      m_left   = 0;
      m_we     = 0;
      m_addr   = 0;
      m_wdata  = 0;
      m_streak = 0;
      m_sc     = 0;
      m_prd    = 0;
      m_erd    = 0;
    end else begin
      if (e_stall && m_sc < SC_MAX) m_sc++;
      if (fin && !m_we) begin
        if (m_ext) m_erd = rd;
        else       m_prd = rd;
      end
      if (fin && m_we) gmem[m_addr[9:2]] = m_wdata;
      if (m_busy) begin
        if (m_left == 1) m_busy = 0;
        else             m_left--;
      end else begin
        pick_ext  = ext_req && (!pipe_req || m_streak == MPS);
        pick_pipe = pipe_req && !pick_ext;
        if (!ext_req) m_streak = 0;
        if (pick_pipe) begin
          if (ext_req) m_streak = (m_streak + 1 > MPS) ? MPS : m_streak + 1;
          m_busy = 1; m_ext = 0; m_left = AC;
          m_we = pipe_we; m_addr = pipe_addr; m_wdata = pipe_wdata;
        end
        if (pick_ext) begin
          m_streak = 0;
          m_busy = 1; m_ext = 1; m_left = AC;
          m_we = ext_we; m_addr = ext_addr; m_wdata = ext_wdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'h0;
      gmem[i]   = 32'h0;
    end
    tb_mem[8'h10] = 32'hDEADBEEF;
    gmem[8'h10]   = 32'hDEADBEEF;

    rst = 1; pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    step(); step();
    rst = 0;
    settle();
    check("rst_busy", 32'(busy), 0);
    check("rst_stall_count", 32'(stall_count), 0);
    check("rst_pipe_rdata", pipe_rdata, 0);
    step();

    // 1: pipe read of 0x43 -> word 0x40
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h43;
    settle(); check("t1_stall_T", 32'(pipe_stall), 1); step();
    settle();
    check("t1_addr_T1", mem_addr, 32'h40);
    check("t1_re_T1", 32'(mem_re), 1);
    check("t1_stall_T1", 32'(pipe_stall), 1);
    step();
    settle();
    check("t1_re_T2", 32'(mem_re), 1);
    check("t1_stall_T2", 32'(pipe_stall), 0);
    check("t1_rdata_T2", pipe_rdata, 32'hDEADBEEF);
    check("t1_count_T2", 32'(stall_count), 2);
    step();
    pipe_req = 0;
    settle(); check("t1_hold", pipe_rdata, 32'hDEADBEEF); check("t1_idle", 32'(busy), 0); step();

    // 2: pipe write 0x80, then read back
    pipe_req = 1; pipe_we = 1; pipe_addr = 32'h80; pipe_wdata = 32'h12345678;
    settle(); check("t2_we_T", 32'(mem_we), 0); step();
    settle(); check("t2_we_T1", 32'(mem_we), 0); check("t2_busy_T1", 32'(busy), 1); step();
    settle();
    check("t2_we_T2", 32'(mem_we), 1);
    check("t2_wdata_T2", mem_wdata, 32'h12345678);
    check("t2_addr_T2", mem_addr, 32'h80);
    step();
    pipe_we = 0;
    settle(); check("t2_rd_stall", 32'(pipe_stall), 1); check("t2_rd_idle", 32'(busy), 0); step();
    step();
    settle(); check("t2_readback", pipe_rdata, 32'h12345678); check("t2_count", 32'(stall_count), 6); step();
    pipe_req = 0; step();

    // 3: simultaneous requests; pipe first, then ext
    pipe_req = 1; pipe_addr = 32'h40; ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    settle(); check("t3_stall_T", 32'(pipe_stall), 1); step();
    settle(); check("t3_edone_T1", 32'(ext_done), 0); step();
    settle();
    check("t3_prd_T2", pipe_rdata, 32'hDEADBEEF);
    check("t3_edone_T2", 32'(ext_done), 0);
    check("t3_stall_T2", 32'(pipe_stall), 0);
    step();
    pipe_req = 0;
    settle(); check("t3_idle_T3", 32'(busy), 0); step();
    pipe_req = 1; pipe_addr = 32'h80;
    settle(); check("t3_busy_T4", 32'(busy), 1); check("t3_stall_T4", 32'(pipe_stall), 1);
    check("t3_eaddr_T4", mem_addr, 32'h40); step();
    settle();
    check("t3_edone_T5", 32'(ext_done), 1);
    check("t3_erd_T5", ext_rdata, 32'hDEADBEEF);
    check("t3_stall_T5", 32'(pipe_stall), 1);
    step();
    ext_req = 0;
    settle(); check("t3_edone_T6", 32'(ext_done), 0); check("t3_erd_hold", ext_rdata, 32'hDEADBEEF);
    check("t3_stall_T6", 32'(pipe_stall), 1); step();
    step();
    settle(); check("t3_prd_T8", pipe_rdata, 32'h12345678); check("t3_stall_T8", 32'(pipe_stall), 0); step();
    pipe_req = 0; step();

    // 4: both held -> four pipe grants, one ext, repeat
    seq = "";
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h40; ext_req = 1; ext_we = 0; ext_addr = 32'h80;
    for (int c = 0; c < 40 && seq.len() < 11; c++) begin
      settle();
      if (ext_done) seq = {seq, "E"};
      else if (busy && pipe_req && !pipe_stall) seq = {seq, "P"};
      step();
    end
    n_tests++;
    if (seq != "PPPPEPPPPEP") begin
      n_fail++;
      $display("FAIL t4_order: got %s expected PPPPEPPPPEP", seq);
    end
    pipe_req = 0; ext_req = 0;
    settle(); check("t4_erd", ext_rdata, 32'h12345678); step();
    settle(); check("t4_sat_count", 32'(s_stall_count), 3); step();

    // 5: ext write aborted by reset, then re-granted
    ext_req = 1; ext_we = 1; ext_addr = 32'h100; ext_wdata = 32'hA5A55A5A;
    settle(); check("t5_idle_T", 32'(busy), 0); step();
    rst = 1; pipe_req = 1;
    settle(); check("t5_we_rst", 32'(mem_we), 0); check("t5_edone_rst", 32'(ext_done), 0);
    check("t5_stall_rst", 32'(pipe_stall), 0); step();
    rst = 0; pipe_req = 0;
    settle();
    check("t5_busy", 32'(busy), 0);
    check("t5_re", 32'(mem_re), 0);
    check("t5_we", 32'(mem_we), 0);
    check("t5_addr", mem_addr, 0);
    check("t5_wdata", mem_wdata, 0);
    check("t5_count", 32'(stall_count), 0);
    check("t5_s_count", 32'(s_stall_count), 0);
    check("t5_prd", pipe_rdata, 0);
    check("t5_erd", ext_rdata, 0);
    check("t5_edone", 32'(ext_done), 0);
    step();
    settle(); check("t5_regrant_busy", 32'(busy), 1); check("t5_regrant_addr", mem_addr, 32'h100);
    check("t5_regrant_we0", 32'(mem_we), 0); step();
    settle(); check("t5_regrant_we1", 32'(mem_we), 1); check("t5_regrant_done", 32'(ext_done), 1);
    check("t5_regrant_wdata", mem_wdata, 32'hA5A55A5A); step();
    ext_req = 0; step();

    // 6: four back-to-back pipe reads; narrow counter saturates at 3
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h100;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i == 2) check("t6_s_count_2", 32'(s_stall_count), 2);
      if (i == 5) check("t6_s_count_5", 32'(s_stall_count), 3);
      step();
    end
    pipe_req = 0;
    settle();
    check("t6_count", 32'(stall_count), 8);
    check("t6_s_count", 32'(s_stall_count), 3);
    check("t6_prd", pipe_rdata, 32'hA5A55A5A);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
